// File: rtl/param_register_file_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file:
//   - FunSel encodings (RF_HOLD .. RF_LDHI, RF_RSVD)
//   - rf_sel_w()       : read-select width for a given register count
//   - rf_next_value()  : next register value for one FunSel. Used by each
//                        storage cell and, through the cells' next_q outputs,
//                        by the optional read bypass.
// -----------------------------------------------------------------------------
package rf_pkg;

    // Widest register the shared next-value function handles. Callers
    // zero-extend into this width and truncate the result back to DATA_W.
    localparam int RF_MAX_W = 256;

    localparam logic [2:0] RF_HOLD = 3'b000;
    localparam logic [2:0] RF_CLR  = 3'b001;
    localparam logic [2:0] RF_LOAD = 3'b010;
    localparam logic [2:0] RF_INC  = 3'b011;
    localparam logic [2:0] RF_DEC  = 3'b100;
    localparam logic [2:0] RF_LDLO = 3'b101;
    localparam logic [2:0] RF_LDHI = 3'b110;
    localparam logic [2:0] RF_RSVD = 3'b111;

    // A single register still needs a 1-bit select field.
    function automatic int rf_sel_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    // Arithmetic runs at RF_MAX_W; truncating to 'width' bits afterwards
    // gives the mod 2^width wrap for increment and decrement.
    function automatic logic [RF_MAX_W-1:0] rf_next_value(
        input logic [2:0]          fun_sel,
        input logic [RF_MAX_W-1:0] q,
        input logic [RF_MAX_W-1:0] din,
        input int                  width
    );
        logic [RF_MAX_W-1:0] lo_mask;
        lo_mask = ~({RF_MAX_W{1'b1}} << (width / 2));
        case (fun_sel)
            RF_CLR:  return '0;
            RF_LOAD: return din;
            RF_INC:  return q + RF_MAX_W'(1);
            RF_DEC:  return q - RF_MAX_W'(1);
            RF_LDLO: return din & lo_mask;
            // Low half of the bus lands in the upper half of the register.
            RF_LDHI: return ((din & lo_mask) << (width / 2)) | (q & lo_mask);
            default: return q;  // RF_HOLD and reserved encoding
        endcase
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// -----------------------------------------------------------------------------
// param_register_file_if
// Write/function bus and read ports of param_register_file.
//   i        write data (DATA_W)
//   RegSel   per-GP enable (NUM_GP)
//   ScrSel   per-scratch enable (NUM_SCR, width 1 and ignored if NUM_SCR == 0)
//   FunSel   function for all enabled registers (3)
//   OutASel  read select A (SEL_W), OutBSel read select B (SEL_W)
//   OutA     registered read data A, OutB registered read data B (DATA_W)
// Modports: master drives the bus and reads the outputs; slave is the file.
// -----------------------------------------------------------------------------
interface param_register_file_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_GP  = 4,
    parameter int NUM_SCR = 4
);
    localparam int SEL_W = rf_pkg::rf_sel_w(NUM_GP + NUM_SCR);
    localparam int SCR_W = (NUM_SCR > 0) ? NUM_SCR : 1;

    logic [DATA_W-1:0] i;
    logic [NUM_GP-1:0] RegSel;
    logic [SCR_W-1:0]  ScrSel;
    logic [2:0]        FunSel;
    logic [SEL_W-1:0]  OutASel;
    logic [SEL_W-1:0]  OutBSel;
    logic [DATA_W-1:0] OutA;
    logic [DATA_W-1:0] OutB;

    modport master (
        output i, RegSel, ScrSel, FunSel, OutASel, OutBSel,
        input  OutA, OutB
    );

    modport slave (
        input  i, RegSel, ScrSel, FunSel, OutASel, OutBSel,
        output OutA, OutB
    );
endinterface

// File: rtl/param_register_file_reg_cell.sv
// -----------------------------------------------------------------------------
// rf_reg_cell
// One DATA_W storage register of the register file.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   en           : apply fun_sel this cycle (otherwise hold)
//   fun_sel      : function code (rf_pkg encodings)
//   i            : write data
//   q            : current value
//   next_q       : value q takes at the next edge (absent reset); equals q
//                  when disabled, so it doubles as the bypass source
// -----------------------------------------------------------------------------
module rf_reg_cell
    import rf_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        fun_sel,
    input  logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] next_q
);

    // NOTE: assign a default before any condition in always_comb so every
    // path drives next_q and no latch is inferred.
    always_comb begin
        next_q = q;
        if (en) begin
            next_q = DATA_W'(rf_next_value(fun_sel, RF_MAX_W'(q), RF_MAX_W'(i), DATA_W));
        end
    end

    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// NUM_GP general-purpose plus NUM_SCR scratch registers, DATA_W bits each.
// One FunSel per cycle is applied to every enabled register; two read ports
// capture the selected register on each rising edge (1-cycle latency).
// Select values >= NUM_GP+NUM_SCR read as 0.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; clears all registers and both outputs
//   bus    : param_register_file_if.slave (i, RegSel, ScrSel, FunSel,
//            OutASel, OutBSel, OutA, OutB)
// Build option RF_BYPASS_EN: read ports capture the post-update value of a
// register being written in the same cycle instead of its current value.
// -----------------------------------------------------------------------------
module param_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_GP  = 4,
    parameter int NUM_SCR = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    param_register_file_if.slave  bus
);

    localparam int NREG = NUM_GP + NUM_SCR;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Cell index: GP[k] at k, SCR[k] at NUM_GP+k, matching the read selects.
    logic [NREG-1:0]   en;
    logic [DATA_W-1:0] q_arr    [NREG];
    logic [DATA_W-1:0] next_arr [NREG];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    generate
        if (NUM_SCR > 0) begin : g_with_scr
            assign en = {bus.ScrSel, bus.RegSel};
        end else begin : g_no_scr
            assign en = bus.RegSel;
        end
    endgenerate

    genvar k;
    generate
        for (k = 0; k < NREG; k++) begin : g_cell
            rf_reg_cell #(.DATA_W(DATA_W)) u_cell (
                .clock   (clock),
                .reset   (reset),
                .en      (en[k]),
                .fun_sel (bus.FunSel),
                .i       (bus.i),
                .q       (q_arr[k]),
                .next_q  (next_arr[k])
            );
        end
    endgenerate

    // Read muxes. A select that matches no cell leaves the default of 0,
    // which covers out-of-range selects.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int r = 0; r < NREG; r++) begin
            if (int'(bus.OutASel) == r) rd_a = BYPASS ? next_arr[r] : q_arr[r];
            if (int'(bus.OutBSel) == r) rd_b = BYPASS ? next_arr[r] : q_arr[r];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.OutA <= '0;
            bus.OutB <= '0;
        end else begin
            bus.OutA <= rd_a;
            bus.OutB <= rd_b;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
// Self-checking bench for param_register_file: a 32/4/4 instance driven from
// a vector table through a scoreboard queue, a 16/6/2 instance for the
// parameter sweep, and an 8/3/0 instance for out-of-range selects and the
// no-scratch configuration.
// -----------------------------------------------------------------------------
module tb_param_register_file;
    import rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    param_register_file_if #(.DATA_W(32), .NUM_GP(4), .NUM_SCR(4)) bus_m ();
    param_register_file_if #(.DATA_W(16), .NUM_GP(6), .NUM_SCR(2)) bus_s ();
    param_register_file_if #(.DATA_W(8),  .NUM_GP(3), .NUM_SCR(0)) bus_t ();

    param_register_file #(.DATA_W(32), .NUM_GP(4), .NUM_SCR(4)) dut_m (
        .clock (clock), .reset (reset), .bus (bus_m.slave));
    param_register_file #(.DATA_W(16), .NUM_GP(6), .NUM_SCR(2)) dut_s (
        .clock (clock), .reset (reset), .bus (bus_s.slave));
    param_register_file #(.DATA_W(8),  .NUM_GP(3), .NUM_SCR(0)) dut_t (
        .clock (clock), .reset (reset), .bus (bus_t.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  reg_sel;
        logic [3:0]  scr_sel;
        logic [2:0]  fun;
        logic [31:0] din;
        logic [2:0]  asel;
        logic [2:0]  bsel;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];

    // Drive one cycle on the 32-bit instance, queue its expected read data,
    // then pop and compare once the edge has been taken.
    task automatic step(input string name, input vec_t v, input logic rst);
        exp_t e;
        @(negedge clock);
        reset         = rst;
        bus_m.RegSel  = v.reg_sel;
        bus_m.ScrSel  = v.scr_sel;
        bus_m.FunSel  = v.fun;
        bus_m.i       = v.din;
        bus_m.OutASel = v.asel;
        bus_m.OutBSel = v.bsel;
        sb.push_back('{name, v.exp_a, v.exp_b});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({e.name, ".A"}, bus_m.OutA, e.a);
        check({e.name, ".B"}, bus_m.OutB, e.b);
    endtask

    task automatic drive_s(input logic [5:0] rs, input logic [1:0] ss, input logic [2:0] fun,
                           input logic [15:0] din, input logic [2:0] asel, input logic [2:0] bsel);
        @(negedge clock);
        bus_s.RegSel = rs;  bus_s.ScrSel = ss;  bus_s.FunSel = fun;
        bus_s.i = din;      bus_s.OutASel = asel; bus_s.OutBSel = bsel;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_t(input logic [2:0] rs, input logic [2:0] fun, input logic [7:0] din,
                           input logic [1:0] asel, input logic [1:0] bsel);
        @(negedge clock);
        bus_t.RegSel = rs;  bus_t.ScrSel = 1'b1;  bus_t.FunSel = fun;
        bus_t.i = din;      bus_t.OutASel = asel; bus_t.OutBSel = bsel;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t        tbl [18];
    vec_t        v;
    logic [15:0] sval [8];

    initial begin
        // Table expectations hold in both builds: a register written in a
        // vector is not read in it, except v15 where the bypass term differs.
        tbl[0]  = '{4'b0001, 4'b0000, RF_LOAD, 32'h11111111, 3'd1, 3'd4, 32'h0, 32'h0};
        tbl[1]  = '{4'b0010, 4'b0000, RF_LOAD, 32'h22222222, 3'd0, 3'd0, 32'h11111111, 32'h11111111};
        tbl[2]  = '{4'b0000, 4'b0001, RF_LOAD, 32'hFFFFFFFF, 3'd1, 3'd0, 32'h22222222, 32'h11111111};
        tbl[3]  = '{4'b0000, 4'b0001, RF_INC,  32'h0,        3'd1, 3'd2, 32'h22222222, 32'h0};
        tbl[4]  = '{4'b0010, 4'b0000, RF_CLR,  32'h0,        3'd4, 3'd0, 32'h0, 32'h11111111};
        tbl[5]  = '{4'b0010, 4'b0000, RF_DEC,  32'h0,        3'd4, 3'd4, 32'h0, 32'h0};
        tbl[6]  = '{4'b1111, 4'b1111, RF_HOLD, 32'h12121212, 3'd4, 3'd1, 32'h0, 32'hFFFFFFFF};
        tbl[7]  = '{4'b0100, 4'b0000, RF_LOAD, 32'hAAAA5555, 3'd0, 3'd1, 32'h11111111, 32'hFFFFFFFF};
        tbl[8]  = '{4'b0100, 4'b0000, RF_LDHI, 32'h0000BEEF, 3'd0, 3'd1, 32'h11111111, 32'hFFFFFFFF};
        tbl[9]  = '{4'b0000, 4'b0000, RF_LOAD, 32'hDEADDEAD, 3'd2, 3'd2, 32'hBEEF5555, 32'hBEEF5555};
        tbl[10] = '{4'b0100, 4'b0000, RF_LDLO, 32'hFFFF1234, 3'd3, 3'd0, 32'h0, 32'h11111111};
        tbl[11] = '{4'b0000, 4'b0000, RF_HOLD, 32'h0,        3'd2, 3'd4, 32'h00001234, 32'h0};
        tbl[12] = '{4'b1000, 4'b1110, RF_LOAD, 32'h5A5A5A5A, 3'd0, 3'd1, 32'h11111111, 32'hFFFFFFFF};
        tbl[13] = '{4'b0000, 4'b0100, RF_DEC,  32'h0,        3'd3, 3'd7, 32'h5A5A5A5A, 32'h5A5A5A5A};
        tbl[14] = '{4'b1111, 4'b1111, RF_RSVD, 32'h77777777, 3'd6, 3'd5, 32'h5A5A5A59, 32'h5A5A5A5A};
        tbl[15] = '{4'b1111, 4'b1111, RF_CLR,  32'h0,        3'd7, 3'd2,
                    BYP ? 32'h0 : 32'h5A5A5A5A, BYP ? 32'h0 : 32'h00001234};
        tbl[16] = '{4'b0000, 4'b0000, RF_HOLD, 32'h0,        3'd0, 3'd7, 32'h0, 32'h0};
        tbl[17] = '{4'b0000, 4'b0000, RF_HOLD, 32'h0,        3'd2, 3'd6, 32'h0, 32'h0};

        // Initial reset of all three instances.
        reset = 1'b1;
        bus_m.RegSel = '0; bus_m.ScrSel = '0; bus_m.FunSel = RF_HOLD; bus_m.i = '0;
        bus_m.OutASel = '0; bus_m.OutBSel = '0;
        bus_s.RegSel = '0; bus_s.ScrSel = '0; bus_s.FunSel = RF_HOLD; bus_s.i = '0;
        bus_s.OutASel = '0; bus_s.OutBSel = '0;
        bus_t.RegSel = '0; bus_t.ScrSel = '0; bus_t.FunSel = RF_HOLD; bus_t.i = '0;
        bus_t.OutASel = '0; bus_t.OutBSel = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst.m.A", bus_m.OutA, 32'h0);
        check("rst.m.B", bus_m.OutB, 32'h0);
        check("rst.s.A", bus_s.OutA, 32'h0);
        check("rst.s.B", bus_s.OutB, 32'h0);
        check("rst.t.A", bus_t.OutA, 32'h0);
        check("rst.t.B", bus_t.OutB, 32'h0);

        for (int n = 0; n < 18; n++) begin
            step($sformatf("vec%0d", n), tbl[n], 1'b0);
        end

        // Read-after-write latency on GP0 (cleared by vec15).
        v = '{4'b0001, 4'b0000, RF_LOAD, 32'h12345678, 3'd0, 3'd0,
              BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0};
        step("lat.edge1", v, 1'b0);
        v = '{4'b0000, 4'b0000, RF_HOLD, 32'h0, 3'd0, 3'd0, 32'h12345678, 32'h12345678};
        step("lat.edge2", v, 1'b0);

        // Reset overrides a simultaneous all-register load.
        v = '{4'b0001, 4'b0000, RF_LOAD, 32'hDEADBEEF, 3'd1, 3'd4, 32'h0, 32'h0};
        step("rst2.load", v, 1'b0);
        v = '{4'b0000, 4'b0000, RF_HOLD, 32'h0, 3'd0, 3'd0, 32'hDEADBEEF, 32'hDEADBEEF};
        step("rst2.read", v, 1'b0);
        v = '{4'b1111, 4'b1111, RF_LOAD, 32'hFFFFFFFF, 3'd0, 3'd0, 32'h0, 32'h0};
        step("rst2.edge", v, 1'b1);
        for (int n = 0; n < 4; n++) begin
            v = '{4'b0000, 4'b0000, RF_HOLD, 32'h0, 3'(n), 3'(7 - n), 32'h0, 32'h0};
            step($sformatf("rst2.clear%0d", n), v, 1'b0);
        end

        // Sweep instance: load distinct values, then read back with plain
        // hold and with the reserved code applied to every register.
        for (int n = 0; n < 8; n++) begin
            sval[n] = 16'(16'h1111 * (n + 1));
            drive_s((n < 6) ? 6'(1 << n) : 6'd0, (n >= 6) ? 2'(1 << (n - 6)) : 2'd0,
                    RF_LOAD, sval[n], 3'd0, 3'd0);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 8; n++) begin
                if (pass == 0) drive_s(6'd0, 2'd0, RF_HOLD, 16'hFFFF, 3'(n), 3'(7 - n));
                else           drive_s(6'h3F, 2'h3, RF_RSVD, 16'hFFFF, 3'(n), 3'(7 - n));
                check($sformatf("sweep.p%0d.A%0d", pass, n), bus_s.OutA, 32'(sval[n]));
                check($sformatf("sweep.p%0d.B%0d", pass, n), bus_s.OutB, 32'(sval[7 - n]));
            end
        end
        drive_s(6'd1, 2'd0, RF_LDHI, 16'h00AB, 3'd1, 3'd1);
        drive_s(6'd0, 2'd0, RF_HOLD, 16'h0,    3'd0, 3'd0);
        check("sweep.ldhi", bus_s.OutA, 32'h0000AB11);
        drive_s(6'd1, 2'd0, RF_LDLO, 16'h34CD, 3'd1, 3'd1);
        drive_s(6'd0, 2'd0, RF_HOLD, 16'h0,    3'd0, 3'd0);
        check("sweep.ldlo", bus_s.OutB, 32'h000000CD);

        // No-scratch instance: select 3 is out of range, ScrSel held high.
        drive_t(3'b001, RF_LOAD, 8'hFF, 2'd0, 2'd0);
        drive_t(3'b010, RF_LOAD, 8'h42, 2'd0, 2'd0);
        drive_t(3'b001, RF_INC,  8'h00, 2'd3, 2'd1);
        check("tiny.oor.A", bus_t.OutA, 32'h0);
        check("tiny.gp1.B", bus_t.OutB, 32'h42);
        drive_t(3'b100, RF_DEC,  8'h00, 2'd1, 2'd3);
        check("tiny.gp1.A", bus_t.OutA, 32'h42);
        check("tiny.oor.B", bus_t.OutB, 32'h0);
        drive_t(3'b000, RF_HOLD, 8'h00, 2'd2, 2'd2);
        check("tiny.decwrap.A", bus_t.OutA, 32'hFF);
        check("tiny.decwrap.B", bus_t.OutB, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
